// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the datapath and the hazard/stall controller.
//   master : controller side, which samples hazard inputs and drives latch/PC control.
//   slave  : datapath side, which drives hazard inputs and samples control.
//   Inputs to the controller:
//     ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, wsel_ex, Rs_id, Rt_id,
//     mispredict_ex, halt_wb
//   Outputs from the controller:
//     pc_en, <latch>_en / <latch>_flush, halt, mem_timeout
//   With PIPELINE_CTRL_PERF_EN defined, the controller also drives
//   stall_cnt, bubble_cnt and flush_cnt.
interface pipeline_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             dREN_mem;
  logic             dWEN_mem;
  logic             dREN_ex;
  logic [REG_W-1:0] wsel_ex;
  logic [REG_W-1:0] Rs_id;
  logic [REG_W-1:0] Rt_id;
  logic             mispredict_ex;
  logic             halt_wb;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halt;
  logic             mem_timeout;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  modport master (
    input  ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, wsel_ex, Rs_id, Rt_id,
           mispredict_ex, halt_wb,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush, halt, mem_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    , output stall_cnt, bubble_cnt, flush_cnt
`endif
  );

  modport slave (
    output ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, wsel_ex, Rs_id, Rt_id,
           mispredict_ex, halt_wb,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush, halt, mem_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    , input stall_cnt, bubble_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: sole owner of the
// enable/flush pairs of IF_ID, ID_EX, EX_MEM, MEM_WB and of the PC load enable.
// Sequences dmem waits, load-use bubbles, mispredict flushes, imem-miss
// bubbles and halt. Latch controls are combinational from state + inputs so
// the latches react in the same cycle; halt and mem_timeout are registered.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous reset, active-high (forces all en=1, flush=1, pc_en=0)
//   bus  : pipeline_ctrl_if.master (hazard inputs in, latch control out)
// Optional feature macro: PIPELINE_CTRL_PERF_EN adds the stall/bubble/flush
// performance counters on the bus.
module pipeline_ctrl #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  pipeline_ctrl_if.master  bus
);

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_e;

  localparam logic [TO_W-1:0] WDOG_MAX = '1;
  localparam logic [TO_W-1:0] WDOG_HIT = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              halt_q, halt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [TO_W-1:0]   wdog_q, wdog_d;

  logic [REG_W-1:0]  wsel_ex;
  logic              dmem_stall_c;
  logic              load_use_c;

  logic pc_en_c;
  logic ifid_en_c, ifid_flush_c;
  logic idex_en_c, idex_flush_c;
  logic exmem_en_c, exmem_flush_c;
  logic memwb_en_c, memwb_flush_c;

  // Hazard detection
  assign wsel_ex      = bus.wsel_ex;
  assign dmem_stall_c = (bus.dREN_mem | bus.dWEN_mem) & ~bus.dhit;
  assign load_use_c   = bus.dREN_ex & (wsel_ex != '0) &
                        ((wsel_ex == bus.Rs_id) | (wsel_ex == bus.Rt_id));

  // State, halt, watchdog registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= RUN;
      halt_q        <= 1'b0;
      mem_timeout_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      halt_q        <= halt_d;
      mem_timeout_q <= mem_timeout_d;
      wdog_q        <= wdog_d;
    end
  end

  // Next state and latch control, highest priority first
  always_comb begin
    state_d       = state_q;
    halt_d        = halt_q;
    mem_timeout_d = mem_timeout_q;
    wdog_d        = wdog_q;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_en_c     = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_en_c    = 1'b0;
    exmem_flush_c = 1'b0;
    memwb_en_c    = 1'b0;
    memwb_flush_c = 1'b0;

    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (bus.halt_wb) begin
      state_d = HALTED;
      halt_d  = 1'b1;
      wdog_d  = '0;
    end else if (dmem_stall_c) begin
      // Full freeze; coincident hazards re-evaluate from the held latches.
      state_d = DWAIT;
      if (wdog_q != WDOG_MAX) wdog_d = wdog_q + TO_W'(1);
      if (wdog_q == WDOG_HIT) mem_timeout_d = 1'b1;
    end else begin
      state_d    = RUN;
      wdog_d     = '0;
      exmem_en_c = 1'b1;
      memwb_en_c = 1'b1;
      if (bus.mispredict_ex) begin
        // Squash the two wrong-path instructions, redirect PC.
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b1;
        idex_en_c    = 1'b1;
        idex_flush_c = 1'b1;
      end else if (load_use_c) begin
        // Hold IF/ID, inject one bubble into ID/EX.
        idex_en_c    = 1'b1;
        idex_flush_c = 1'b1;
      end else if (!bus.ihit) begin
        // Imem miss: bubble into IF/ID, let the rest drain.
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b1;
        idex_en_c    = 1'b1;
      end else begin
        pc_en_c   = 1'b1;
        ifid_en_c = 1'b1;
        idex_en_c = 1'b1;
      end
    end

    // Reset clears every latch on the reset edge and holds PC.
    if (RST) begin
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b1;
      ifid_flush_c  = 1'b1;
      idex_en_c     = 1'b1;
      idex_flush_c  = 1'b1;
      exmem_en_c    = 1'b1;
      exmem_flush_c = 1'b1;
      memwb_en_c    = 1'b1;
      memwb_flush_c = 1'b1;
    end
  end

  assign bus.pc_en       = pc_en_c;
  assign bus.ifid_en     = ifid_en_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_en     = idex_en_c;
  assign bus.idex_flush  = idex_flush_c;
  assign bus.exmem_en    = exmem_en_c;
  assign bus.exmem_flush = exmem_flush_c;
  assign bus.memwb_en    = memwb_en_c;
  assign bus.memwb_flush = memwb_flush_c;
  assign bus.halt        = halt_q;
  assign bus.mem_timeout = mem_timeout_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic             active_c;
  logic             stall_ev_c, bubble_ev_c, flush_ev_c;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Events mirror the priority chain; nothing counts once halted.
  assign active_c    = (state_q != HALTED) & ~bus.halt_wb;
  assign stall_ev_c  = active_c & dmem_stall_c;
  assign flush_ev_c  = active_c & ~dmem_stall_c & bus.mispredict_ex;
  assign bubble_ev_c = active_c & ~dmem_stall_c & ~bus.mispredict_ex & load_use_c;

  always_comb begin
    stall_cnt_d  = stall_cnt_q  + CNT_W'(stall_ev_c);
    bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble_ev_c);
    flush_cnt_d  = flush_cnt_q  + CNT_W'(flush_ev_c);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// traffic, compared every cycle against a priority-rule reference model.
module tb_pipeline_ctrl;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned TO_W    = 8;
  localparam int unsigned TIMEOUT = 200;
  localparam int unsigned CNT_W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.REG_W(REG_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_known  = 1'b0;
  bit          m_halted = 1'b0;
  bit          m_to     = 1'b0;
  int          m_wdog   = 0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_bubble = '0;
  logic [31:0] m_flush  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit f_stall();
    return (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit;
  endfunction

  function automatic bit f_load_use();
    return bus.dREN_ex && bus.wsel_ex != 0 &&
           (bus.wsel_ex == bus.Rs_id || bus.wsel_ex == bus.Rt_id);
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
  function automatic logic [8:0] exp_ctrl();
    if (rst)                               return 9'b0_11_11_11_11;
    if (m_halted || bus.halt_wb)           return 9'b0_00_00_00_00;
    if (f_stall())                         return 9'b0_00_00_00_00;
    if (bus.mispredict_ex)                 return 9'b1_11_11_10_10;
    if (f_load_use())                      return 9'b0_00_11_10_10;
    if (!bus.ihit)                         return 9'b0_11_10_10_10;
    return 9'b1_10_10_10_10;
  endfunction

  function automatic logic [8:0] act_ctrl();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
            bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush};
  endfunction

  task automatic model_update();
    if (rst) begin
      m_known = 1'b1; m_halted = 1'b0; m_to = 1'b0; m_wdog = 0;
      m_stall = '0; m_bubble = '0; m_flush = '0;
    end else if (!m_known || m_halted) begin
      // nothing changes
    end else if (bus.halt_wb) begin
      m_halted = 1'b1; m_wdog = 0;
    end else if (f_stall()) begin
      if (m_wdog == TIMEOUT - 1) m_to = 1'b1;
      m_stall++;
      m_wdog = (m_wdog >= (1 << TO_W) - 1) ? m_wdog : m_wdog + 1;
    end else begin
      m_wdog = 0;
      if (bus.mispredict_ex) m_flush++;
      else if (f_load_use()) m_bubble++;
    end
  endtask

  // One clock: inputs already driven after a falling edge; compare, then advance.
  task automatic cycle(input string tag);
    #1;
    check({tag, "/ctrl"}, 32'(act_ctrl()), 32'(exp_ctrl()));
    if (m_known) begin
      check({tag, "/halt"}, 32'(bus.halt), 32'(m_halted));
      check({tag, "/mem_timeout"}, 32'(bus.mem_timeout), 32'(m_to));
`ifdef PIPELINE_CTRL_PERF_EN
      check({tag, "/stall_cnt"}, 32'(bus.stall_cnt), m_stall);
      check({tag, "/bubble_cnt"}, 32'(bus.bubble_cnt), m_bubble);
      check({tag, "/flush_cnt"}, 32'(bus.flush_cnt), m_flush);
`endif
    end
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ih, input logic dh, input logic drm, input logic dwm,
                       input logic dre, input logic [REG_W-1:0] ws, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt, input logic mis, input logic hw);
    bus.ihit = ih; bus.dhit = dh; bus.dREN_mem = drm; bus.dWEN_mem = dwm;
    bus.dREN_ex = dre; bus.wsel_ex = ws; bus.Rs_id = rs; bus.Rt_id = rt;
    bus.mispredict_ex = mis; bus.halt_wb = hw;
  endtask

  task automatic drive_idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive_random(input bit allow_halt);
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 1)),
          REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
          1'($urandom_range(0, 7) == 0),
          allow_halt ? 1'($urandom_range(0, 63) == 0) : 1'b0);
  endtask

  initial begin
    drive_idle();
    @(negedge clk);

    // Reset held two cycles
    rst = 1'b1;
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;
    cycle("run_after_rst");

    // dmem load stall three cycles, then completion
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("dwait");
    bus.dhit = 1'b1;
    cycle("dwait_release");
    drive_idle();
    cycle("idle");

    // Load-use on Rt, then wsel_ex=0 must not bubble
    drive(1, 1, 0, 0, 1, 5, 3, 5, 0, 0);
    cycle("load_use_rt");
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    cycle("load_use_r0");

    // Mispredict beats load-use
    drive(1, 1, 0, 0, 1, 7, 7, 2, 1, 0);
    cycle("mispredict_vs_lu");

    // Imem miss
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("imem_miss");

    // Mispredict coincident with dmem stall: freeze wins
    drive(1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    cycle("stall_vs_mispredict");
    bus.dhit = 1'b1;
    cycle("mispredict_after_stall");

    // Random traffic, no halt
    for (int i = 0; i < 400; i++) begin
      drive_random(1'b0);
      cycle("random");
    end

    // Watchdog: store stalled TIMEOUT cycles
    rst = 1'b1; drive_idle();
    cycle("rst_wdog");
    rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < int'(TIMEOUT); i++) cycle("wdog_stall");
    check("timeout_after_edge", 32'(bus.mem_timeout), 32'd1);
    bus.dhit = 1'b1;
    cycle("wdog_release");
    drive_idle();
    cycle("wdog_sticky");

    // Random traffic with occasional halt
    for (int i = 0; i < 300; i++) begin
      drive_random(1'b1);
      cycle("random_halt");
    end

    // Halt concurrent with dmem stall, then everything frozen until reset
    rst = 1'b1; drive_idle();
    cycle("rst_halt");
    rst = 1'b0;
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    cycle("halt_vs_stall");
    check("halt_set", 32'(bus.halt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive_random(1'b0);
      cycle("halted");
    end
    rst = 1'b1; drive_idle();
    cycle("rst_from_halt");
    rst = 1'b0;
    cycle("run_after_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
